// File: rtl/pwm_capture_multi.sv
// pwm_capture_multi
//   Multi-channel PWM pulse-width receiver. Each channel synchronises its PWM
//   input, measures the active phase in clk cycles, publishes the result with
//   a one-cycle valid strobe, flags saturation and drops back to idle after a
//   programmable period without input transitions.
//
// Ports
//   i_clk      : single clock, rising edge
//   i_reset    : synchronous, active-low reset
//   i_pwm      : asynchronous PWM inputs, bit i = channel i
//   o_position : last measured width, channel i at [i*WIDTH +: WIDTH]
//   o_valid    : one-cycle strobe when position/sat take a new measurement
//   o_sat      : current position was clipped at 2^WIDTH-1
//   o_active   : channel has measured since the last reset or timeout
module pwm_capture_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 10,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int INVERT      = 0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [CHANNELS-1:0]       i_pwm,
  output logic [CHANNELS*WIDTH-1:0] o_position,
  output logic [CHANNELS-1:0]       o_valid,
  output logic [CHANNELS-1:0]       o_sat,
  output logic [CHANNELS-1:0]       o_active
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    TMR_FULL = TW'(TIMEOUT);
  localparam logic             INV_BIT  = (INVERT != 0);
  // Raw level that makes the synchronised sample read as active, so the
  // FSM must see an inactive sample before it can start a measurement.
  localparam logic             SYNC_RST = ~INV_BIT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [TW-1:0]          r_timer;
    logic [WIDTH-1:0]       r_cnt;
    logic                   r_cnt_sat;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_pos;
    logic                   r_valid;
    logic                   r_sat;
    logic                   r_active;
    logic                   w_s;
    logic                   w_edge;
    logic                   w_timeout;
    logic                   w_load;
    logic                   w_inc;
    logic                   w_publish;

    assign w_s       = r_sync[SYNC_STAGES-1] ^ INV_BIT;
    assign w_edge    = (w_s != r_prev);
    // A transition always wins, so the timer only fires on a quiet sample.
    assign w_timeout = !w_edge && (r_timer == TMR_LAST);

    // Input synchroniser chain
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        r_sync <= {SYNC_STAGES{SYNC_RST}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm[g]};
      end
    end

    // Previous sample and idle timer (saturates so the timeout fires once)
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        r_prev  <= SYNC_RST ^ INV_BIT;
        r_timer <= {TW{1'b0}};
      end else begin
        r_prev <= w_s;
        if (w_edge) begin
          r_timer <= {TW{1'b0}};
        end else if (r_timer != TMR_FULL) begin
          r_timer <= r_timer + TMR_ONE;
        end
      end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // FSM next-state logic
    always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  w_state_nxt = w_s ? ST_IDLE  : ST_ARMED;
          ST_ARMED: w_state_nxt = w_s ? ST_COUNT : ST_ARMED;
          ST_COUNT: w_state_nxt = w_s ? ST_COUNT : ST_ARMED;
          default:  w_state_nxt = ST_IDLE;
        endcase
      end
    end

    // FSM action decode
    always_comb begin
      w_load    = 1'b0;
      w_inc     = 1'b0;
      w_publish = 1'b0;
      if (w_timeout) begin
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_publish = 1'b0;
      end else begin
        case (r_state)
          ST_ARMED: w_load = w_s;
          ST_COUNT: begin
            w_inc     = w_s;
            w_publish = !w_s;
          end
          default: begin
            w_load    = 1'b0;
            w_inc     = 1'b0;
            w_publish = 1'b0;
          end
        endcase
      end
    end

    // Width counter; holds at full scale and remembers that it clipped
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        r_cnt     <= {WIDTH{1'b0}};
        r_cnt_sat <= 1'b0;
      end else if (w_load) begin
        r_cnt     <= CNT_ONE;
        r_cnt_sat <= 1'b0;
      end else if (w_inc) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt_sat <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end

    // Published result registers
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        r_pos    <= {WIDTH{1'b0}};
        r_valid  <= 1'b0;
        r_sat    <= 1'b0;
        r_active <= 1'b0;
      end else begin
        r_valid <= w_publish;
        if (w_publish) begin
          r_pos    <= r_cnt;
          r_sat    <= r_cnt_sat;
          r_active <= 1'b1;
        end else if (w_timeout) begin
          r_pos    <= {WIDTH{1'b0}};
          r_sat    <= 1'b0;
          r_active <= 1'b0;
        end
      end
    end

    assign o_position[g*WIDTH +: WIDTH] = r_pos;
    assign o_valid[g]                   = r_valid;
    assign o_sat[g]                     = r_sat;
    assign o_active[g]                  = r_active;
  end

endmodule

// File: tb/tb_pwm_capture_multi.sv
// tb_pwm_capture_multi
//   Directed bench for pwm_capture_multi. Three instances share clock and
//   reset: A (defaults), B (TIMEOUT=2048, for saturation), C (INVERT=1).
//   A sample-level model of the receiver rules is compared against every
//   instance on every cycle, plus literal expectations at key points.
module tb_pwm_capture_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pwm_a, pwm_b, pwm_c;
  logic [39:0] pos_a, pos_b, pos_c;
  logic [3:0]  vld_a, vld_b, vld_c;
  logic [3:0]  sat_a, sat_b, sat_c;
  logic [3:0]  act_a, act_b, act_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pwm_capture_multi #(.CHANNELS(4), .WIDTH(10), .TIMEOUT(1024), .SYNC_STAGES(2), .INVERT(0)) u_dut_a (
    .i_clk(clk), .i_reset(reset_n), .i_pwm(pwm_a),
    .o_position(pos_a), .o_valid(vld_a), .o_sat(sat_a), .o_active(act_a));

  pwm_capture_multi #(.CHANNELS(4), .WIDTH(10), .TIMEOUT(2048), .SYNC_STAGES(2), .INVERT(0)) u_dut_b (
    .i_clk(clk), .i_reset(reset_n), .i_pwm(pwm_b),
    .o_position(pos_b), .o_valid(vld_b), .o_sat(sat_b), .o_active(act_b));

  pwm_capture_multi #(.CHANNELS(4), .WIDTH(10), .TIMEOUT(1024), .SYNC_STAGES(2), .INVERT(1)) u_dut_c (
    .i_clk(clk), .i_reset(reset_n), .i_pwm(pwm_c),
    .o_position(pos_c), .o_valid(vld_c), .o_sat(sat_c), .o_active(act_c));

  // ---------------- behavioural model ----------------
  int   to_p [3] = '{1024, 2048, 1024};
  bit   inv_p[3] = '{1'b0, 1'b0, 1'b1};

  logic [1:0] m_dl  [3][4];  // last two raw samples (after inversion)
  bit   m_prev [3][4];
  int   m_last [3][4];       // edge number of the last transition of s
  bit   m_elig [3][4];       // an inactive sample has been seen
  int   m_run  [3][4];       // length of the active run being measured
  int   m_pos  [3][4];
  bit   m_sat  [3][4];
  bit   m_act  [3][4];
  bit   m_vld  [3][4];
  int   edge_no = 0;
  bit   m_init  = 1'b0;

  function automatic bit raw_of(input int i, input int c);
    case (i)
      0:       return pwm_a[c];
      1:       return pwm_b[c];
      default: return pwm_c[c];
    endcase
  endfunction

  function automatic logic [3:0] vld_of(input int i);
    case (i)
      0:       return vld_a;
      1:       return vld_b;
      default: return vld_c;
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        bit s;
        bit quiet_out;
        if (!reset_n) begin
          m_dl[i][c]   = 2'b11;
          m_prev[i][c] = 1'b1;
          m_last[i][c] = edge_no;
          m_elig[i][c] = 1'b0;
          m_run[i][c]  = 0;
          m_pos[i][c]  = 0;
          m_sat[i][c]  = 1'b0;
          m_act[i][c]  = 1'b0;
          m_vld[i][c]  = 1'b0;
        end else begin
          s = m_dl[i][c][1];
          m_dl[i][c] = {m_dl[i][c][0], raw_of(i, c) ^ inv_p[i]};
          m_vld[i][c] = 1'b0;
          if (s != m_prev[i][c]) m_last[i][c] = edge_no;
          quiet_out = (s == m_prev[i][c]) && (edge_no - m_last[i][c] == to_p[i]);
          m_prev[i][c] = s;
          if (quiet_out) begin
            m_elig[i][c] = 1'b0;
            m_run[i][c]  = 0;
            m_pos[i][c]  = 0;
            m_sat[i][c]  = 1'b0;
            m_act[i][c]  = 1'b0;
          end else if (!s) begin
            if (m_run[i][c] > 0) begin
              m_pos[i][c] = (m_run[i][c] > 1023) ? 1023 : m_run[i][c];
              m_sat[i][c] = (m_run[i][c] > 1023);
              m_vld[i][c] = 1'b1;
              m_act[i][c] = 1'b1;
            end
            m_run[i][c]  = 0;
            m_elig[i][c] = 1'b1;
          end else if (m_elig[i][c]) begin
            m_run[i][c] = m_run[i][c] + 1;
          end
        end
      end
    end
    if (!reset_n) m_init = 1'b1;
    edge_no++;
  endtask

  task automatic compare();
    logic [39:0] dp, ep;
    logic [3:0]  dv, ev, ds, es, da, ea;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin dp = pos_a; dv = vld_a; ds = sat_a; da = act_a; end
        1:       begin dp = pos_b; dv = vld_b; ds = sat_b; da = act_b; end
        default: begin dp = pos_c; dv = vld_c; ds = sat_c; da = act_c; end
      endcase
      for (int c = 0; c < 4; c++) begin
        ep[c*10 +: 10] = 10'(m_pos[i][c]);
        ev[c] = m_vld[i][c];
        es[c] = m_sat[i][c];
        ea[c] = m_act[i][c];
      end
      n_checks++;
      if ({dp, dv, ds, da} !== {ep, ev, es, ea}) begin
        n_err++;
        $display("FAIL model_cmp inst=%0d edge=%0d got pos=%h vld=%b sat=%b act=%b, expected pos=%h vld=%b sat=%b act=%b",
                 i, edge_no, dp, dv, ds, da, ep, ev, es, ea);
      end
    end
  endtask

  // Compare process: model advances on each rising edge, outputs checked 1 unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_init) compare();
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int inst, input int ch, input int maxc, input string name);
    bit found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(posedge clk);
      #1;
      if (vld_of(inst)[ch] === 1'b1) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic no_valid(input int inst, input int ch, input int n, input string name);
    bit seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (vld_of(inst)[ch] !== 1'b0) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    pwm_a   = 4'h0;
    pwm_b   = 4'h0;
    pwm_c   = 4'hF;
    negs(3);
    chk("reset_pos_a", pos_a, 32'd0);
    chk("reset_act_a", 32'(act_a), 32'd0);
    chk("reset_vld_a", 32'(vld_a), 32'd0);
    chk("reset_pos_c", pos_c[31:0], 32'd0);
    reset_n = 1'b1;
    negs(5);

    // Single 300-cycle pulse on A ch0, latency 3 after the fall
    pwm_a[0] = 1'b1;
    negs(300);
    pwm_a[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("single_early_valid", 32'(vld_a[0]), 32'd0);
    end
    @(posedge clk); #1;
    chk("single_valid", 32'(vld_a), 32'd1);
    chk("single_pos", 32'(pos_a[9:0]), 32'd300);
    chk("single_sat", 32'(sat_a[0]), 32'd0);
    chk("single_active", 32'(act_a), 32'd1);
    chk("single_others_pos", 32'(pos_a[39:10]), 32'd0);
    chk("model_single_pos", 32'(m_pos[0][0]), 32'd300);
    @(posedge clk); #1;
    chk("single_valid_once", 32'(vld_a[0]), 32'd0);

    // Stuck low: timeout exactly 1024 samples after the fall
    repeat (1022) @(posedge clk);
    #1;
    chk("low_tmo_before_act", 32'(act_a[0]), 32'd1);
    chk("low_tmo_before_pos", 32'(pos_a[9:0]), 32'd300);
    @(posedge clk); #1;
    chk("low_tmo_act", 32'(act_a[0]), 32'd0);
    chk("low_tmo_pos", 32'(pos_a[9:0]), 32'd0);
    chk("low_tmo_no_valid", 32'(vld_a[0]), 32'd0);
    chk("model_low_tmo_act", 32'(m_act[0][0]), 32'd0);

    // New 50-cycle measurement, then stuck high
    @(negedge clk);
    negs(2);
    pwm_a[0] = 1'b1;
    negs(50);
    pwm_a[0] = 1'b0;
    wait_valid(0, 0, 10, "pulse50_valid");
    chk("pulse50_pos", 32'(pos_a[9:0]), 32'd50);
    @(negedge clk);
    pwm_a[0] = 1'b1;
    repeat (3) @(posedge clk);
    repeat (1023) @(posedge clk);
    #1;
    chk("high_tmo_before_act", 32'(act_a[0]), 32'd1);
    @(posedge clk); #1;
    chk("high_tmo_act", 32'(act_a[0]), 32'd0);
    chk("high_tmo_pos", 32'(pos_a[9:0]), 32'd0);
    chk("high_tmo_no_valid", 32'(vld_a[0]), 32'd0);
    @(negedge clk);
    pwm_a[0] = 1'b0;
    no_valid(0, 0, 10, "high_tmo_release_no_valid");

    // Reset during a 200-cycle pulse (cycles 50..52), then a 120-cycle pulse
    @(negedge clk);
    pwm_a[0] = 1'b1;
    negs(50);
    reset_n = 1'b0;
    negs(3);
    reset_n = 1'b1;
    chk("midreset_pos", 32'(pos_a[9:0]), 32'd0);
    negs(147);
    pwm_a[0] = 1'b0;
    no_valid(0, 0, 10, "midreset_no_report");
    @(negedge clk);
    pwm_a[0] = 1'b1;
    negs(120);
    pwm_a[0] = 1'b0;
    wait_valid(0, 0, 10, "pulse120_valid");
    chk("pulse120_pos", 32'(pos_a[9:0]), 32'd120);
    chk("pulse120_sat", 32'(sat_a[0]), 32'd0);

    // Simultaneous fall on all four channels: widths 1, 2, 512, 1023
    @(negedge clk);
    reset_n = 1'b0;
    negs(1);
    reset_n = 1'b1;
    negs(20);
    pwm_a[3] = 1'b1;
    negs(511);
    pwm_a[2] = 1'b1;
    negs(510);
    pwm_a[1] = 1'b1;
    negs(1);
    pwm_a[0] = 1'b1;
    negs(1);
    pwm_a = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("multi_early_valid", 32'(vld_a), 32'd0);
    @(posedge clk); #1;
    chk("multi_valid", 32'(vld_a), 32'hF);
    chk("multi_pos0", 32'(pos_a[9:0]), 32'd1);
    chk("multi_pos1", 32'(pos_a[19:10]), 32'd2);
    chk("multi_pos2", 32'(pos_a[29:20]), 32'd512);
    chk("multi_pos3", 32'(pos_a[39:30]), 32'd1023);
    chk("multi_sat", 32'(sat_a), 32'd0);
    chk("model_multi_pos3", 32'(m_pos[0][3]), 32'd1023);

    // Saturation on B: 1500 -> 1023 clipped, then 40 unclipped
    @(negedge clk);
    pwm_b[0] = 1'b1;
    negs(1500);
    pwm_b[0] = 1'b0;
    wait_valid(1, 0, 10, "sat_valid");
    chk("sat_pos", 32'(pos_b[9:0]), 32'd1023);
    chk("sat_flag", 32'(sat_b[0]), 32'd1);
    chk("model_sat_flag", 32'(m_sat[1][0]), 32'd1);
    negs(5);
    pwm_b[0] = 1'b1;
    negs(40);
    pwm_b[0] = 1'b0;
    wait_valid(1, 0, 10, "sat_next_valid");
    chk("sat_next_pos", 32'(pos_b[9:0]), 32'd40);
    chk("sat_next_flag", 32'(sat_b[0]), 32'd0);

    // INVERT=1 on C: a low phase already running at reset is not measured
    @(negedge clk);
    pwm_c[0] = 1'b0;
    reset_n  = 1'b0;
    negs(2);
    reset_n  = 1'b1;
    negs(100);
    pwm_c[0] = 1'b1;
    no_valid(2, 0, 8, "inv_partial_no_report");
    chk("inv_partial_pos", 32'(pos_c[9:0]), 32'd0);
    chk("inv_partial_act", 32'(act_c[0]), 32'd0);
    @(negedge clk);
    pwm_c[0] = 1'b0;
    negs(77);
    pwm_c[0] = 1'b1;
    wait_valid(2, 0, 10, "inv_valid");
    chk("inv_pos", 32'(pos_c[9:0]), 32'd77);
    chk("inv_sat", 32'(sat_c[0]), 32'd0);
    chk("inv_act", 32'(act_c[0]), 32'd1);

    negs(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
